// File: rtl/seq_detect_pkg.sv
// Elaboration-time helpers for the parametrised serial-pattern detector:
// KMP transition function, pattern border and state-width calculation.
package seq_detect_pkg;

    localparam int unsigned MIN_PAT_LEN = 2;
    localparam int unsigned MAX_PAT_LEN = 32;

    function automatic int unsigned calc_st_w(input int unsigned len);
        return (len < 2) ? 1 : $clog2(len);
    endfunction

    // Bit i in arrival order; the pattern MSB is received first.
    function automatic logic pat_bit(input logic [31:0] pattern,
                                     input int unsigned len,
                                     input int unsigned i);
        return pattern[len - 1 - i];
    endfunction

    function automatic int unsigned border(input logic [31:0] pattern,
                                           input int unsigned len);
        int unsigned best;
        logic        ok;
        best = 0;
        for (int unsigned k = 1; k < len; k++) begin
            ok = 1'b1;
            for (int unsigned j = 0; j < k; j++) begin
                if (pat_bit(pattern, len, j) != pat_bit(pattern, len, len - k + j)) begin
                    ok = 1'b0;
                end
            end
            if (ok) begin
                best = k;
            end
        end
        return best;
    endfunction

    // Longest suffix of (matched prefix, new bit) that is a proper prefix of the pattern.
    function automatic int unsigned next_state(input logic [31:0] pattern,
                                               input int unsigned len,
                                               input int unsigned ps,
                                               input logic        in_bit);
        logic [32:0] seen;
        int unsigned kmax;
        int unsigned best;
        logic        ok;
        seen = '0;
        for (int unsigned j = 0; j < ps; j++) begin
            seen[j] = pat_bit(pattern, len, j);
        end
        seen[ps] = in_bit;
        kmax = (ps + 1 < len - 1) ? ps + 1 : len - 1;
        best = 0;
        for (int unsigned k = 1; k <= kmax; k++) begin
            ok = 1'b1;
            for (int unsigned j = 0; j < k; j++) begin
                if (seen[ps + 1 - k + j] != pat_bit(pattern, len, j)) begin
                    ok = 1'b0;
                end
            end
            if (ok) begin
                best = k;
            end
        end
        return best;
    endfunction

endpackage

// File: rtl/seq_det_sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module seq_det_sat_cnt #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/seq_detect_param.sv
// Parametrised Mealy serial-pattern detector driven by an elaboration-time KMP table,
// with input-valid qualifier, registered detect copy and saturating detect counter.
module seq_detect_param
    import seq_detect_pkg::*;
#(
    parameter int               PAT_LEN = 6,
    parameter logic [PAT_LEN-1:0] PATTERN = 6'b111010,
    parameter bit               OVERLAP = 1'b1,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    input  logic             in_seq,
    output logic             det_out,
    output logic             det_reg,
    output logic [CNT_W-1:0] det_count
);

    localparam int unsigned ST_W   = calc_st_w(PAT_LEN);
    localparam logic [31:0] PAT32  = 32'(PATTERN);
    localparam int unsigned BORDER = border(PAT32, PAT_LEN);

    localparam logic [ST_W-1:0] ST_IDLE    = '0;
    localparam logic [ST_W-1:0] ST_LAST    = ST_W'(PAT_LEN - 1);
    localparam logic [ST_W-1:0] ST_RESTART = OVERLAP ? ST_W'(BORDER) : ST_IDLE;

    if ((PAT_LEN < MIN_PAT_LEN) || (PAT_LEN > MAX_PAT_LEN)) begin : g_bad_len
        $error("seq_detect_param: PAT_LEN=%0d outside 2..32", PAT_LEN);
    end
    if (CNT_W < 1) begin : g_bad_cnt
        $error("seq_detect_param: CNT_W must be at least 1");
    end

    logic [ST_W-1:0]    r_ps;
    logic               r_det_reg;
    logic [ST_W-1:0]    w_ns;
    logic [ST_W-1:0]    w_ns_tbl [PAT_LEN][2];
    logic [PAT_LEN-1:0] w_exp_tbl;
    logic               w_exp;
    logic               w_hit;

    // Constant transition and expected-bit tables, one row per matched-prefix length.
    for (genvar gp = 0; gp < PAT_LEN; gp++) begin : g_tbl
        localparam int unsigned NS0 = next_state(PAT32, PAT_LEN, gp, 1'b0);
        localparam int unsigned NS1 = next_state(PAT32, PAT_LEN, gp, 1'b1);
        assign w_ns_tbl[gp][0] = ST_W'(NS0);
        assign w_ns_tbl[gp][1] = ST_W'(NS1);
        assign w_exp_tbl[gp]   = PATTERN[PAT_LEN-1-gp];
    end

    assign w_exp = w_exp_tbl[r_ps];
    assign w_hit = rst & ~clr & in_valid & (in_seq == w_exp) & (r_ps == ST_LAST);

    always_comb begin
        w_ns = r_ps;
        if (clr) begin
            w_ns = ST_IDLE;
        end else if (in_valid) begin
            if (w_hit) begin
                w_ns = ST_RESTART;
            end else begin
                w_ns = w_ns_tbl[r_ps][in_seq];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ps      <= ST_IDLE;
            r_det_reg <= 1'b0;
        end else begin
            r_ps      <= w_ns;
            r_det_reg <= w_hit;
        end
    end

    seq_det_sat_cnt #(
        .WIDTH(CNT_W)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (w_hit),
        .clr  (clr),
        .count(det_count)
    );

    assign det_out = w_hit;
    assign det_reg = r_det_reg;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: default pattern, 1010 with and without overlap,
// and a 2-bit counter instance, all fed from one shared serial stream.
module tb_seq_detect_param;

    logic       clk;
    logic       rst;
    logic       clr;
    logic       in_valid;
    logic       in_seq;

    logic       def_out, def_reg;
    logic [7:0] def_cnt;
    logic       ov_out, ov_reg;
    logic [7:0] ov_cnt;
    logic       nov_out, nov_reg;
    logic [7:0] nov_cnt;
    logic       c2_out, c2_reg;
    logic [1:0] c2_cnt;

    int n_checks = 0;
    int n_err    = 0;

    logic     exp_reg;
    int       exp_def, exp_ov, exp_nov, exp_c2;

    seq_detect_param u_def (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_seq(in_seq),
        .det_out(def_out), .det_reg(def_reg), .det_count(def_cnt)
    );

    seq_detect_param #(.PAT_LEN(4), .PATTERN(4'b1010), .OVERLAP(1'b1)) u_ov (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_seq(in_seq),
        .det_out(ov_out), .det_reg(ov_reg), .det_count(ov_cnt)
    );

    seq_detect_param #(.PAT_LEN(4), .PATTERN(4'b1010), .OVERLAP(1'b0)) u_nov (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_seq(in_seq),
        .det_out(nov_out), .det_reg(nov_reg), .det_count(nov_cnt)
    );

    seq_detect_param #(.CNT_W(2)) u_c2 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_seq(in_seq),
        .det_out(c2_out), .det_reg(c2_reg), .det_count(c2_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_counts();
        chk("def_count", 32'(def_cnt), 32'(exp_def));
        chk("ov_count",  32'(ov_cnt),  32'(exp_ov));
        chk("nov_count", 32'(nov_cnt), 32'(exp_nov));
        chk("c2_count",  32'(c2_cnt),  32'(exp_c2));
    endtask

    // Drives n cycles MSB-first; masks give per-cycle valid, data and expected detects.
    task automatic run(input logic [31:0] vm, input logic [31:0] bits,
                       input logic [31:0] mdef, input logic [31:0] mov,
                       input logic [31:0] mnov, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("def_det_reg", 32'(def_reg), 32'(exp_reg));
            chk_counts();
            clr      = 1'b0;
            in_valid = vm[n-1-i];
            in_seq   = bits[n-1-i];
            #1;
            chk("def_det_out", 32'(def_out), 32'(mdef[n-1-i]));
            chk("c2_det_out",  32'(c2_out),  32'(mdef[n-1-i]));
            chk("ov_det_out",  32'(ov_out),  32'(mov[n-1-i]));
            chk("nov_det_out", 32'(nov_out), 32'(mnov[n-1-i]));
            exp_reg = mdef[n-1-i];
            if (mdef[n-1-i] && exp_def < 255) exp_def++;
            if (mdef[n-1-i] && exp_c2 < 3)    exp_c2++;
            if (mov[n-1-i]  && exp_ov < 255)  exp_ov++;
            if (mnov[n-1-i] && exp_nov < 255) exp_nov++;
        end
        @(negedge clk);
        chk("def_det_reg", 32'(def_reg), 32'(exp_reg));
        chk_counts();
        in_valid = 1'b0;
        in_seq   = 1'b0;
        exp_reg  = 1'b0;
    endtask

    task automatic do_clr();
        @(negedge clk);
        clr      = 1'b1;
        in_valid = 1'b0;
        in_seq   = 1'b0;
        #1;
        chk("clr_det_out", 32'(def_out), 32'h0);
        exp_reg = 1'b0;
        exp_def = 0;
        exp_ov  = 0;
        exp_nov = 0;
        exp_c2  = 0;
    endtask

    initial begin
        rst      = 1'b0;
        clr      = 1'b0;
        in_valid = 1'b0;
        in_seq   = 1'b0;
        exp_reg  = 1'b0;
        exp_def  = 0;
        exp_ov   = 0;
        exp_nov  = 0;
        exp_c2   = 0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ps",      32'(u_def.r_ps), 32'h0);
        chk("rst_det_reg", 32'(def_reg),    32'h0);
        chk("rst_det_out", 32'(def_out),    32'h0);
        chk_counts();
        rst = 1'b1;

        // 1: single pattern 111010
        do_clr();
        run(32'b111111, 32'b111010, 32'b000001, 32'b000001, 32'b000001, 6);
        chk("t1_ps", 32'(u_def.r_ps), 32'h0);

        // 2: mismatch from 11101 falls back to 11, detect on bit 10 only
        do_clr();
        run(32'h3FF, 32'b1110111010, 32'b0000000001, 32'b0000000001, 32'b0000000001, 10);

        // 3: 101010 overlap vs non-overlap for 1010
        do_clr();
        run(32'b111111, 32'b101010, 32'b000000, 32'b000101, 32'b000100, 6);
        chk("t3_ov_ps",  32'(u_ov.r_ps),  32'h2);
        chk("t3_nov_ps", 32'(u_nov.r_ps), 32'h2);

        // 4: invalid cycles carry noise and must be ignored
        do_clr();
        run(32'b10101100101, 32'b10111010110, 32'b00000000001,
            32'b00000000001, 32'b00000000001, 11);

        // 5: reset mid-pattern discards partial match
        run(32'b1111, 32'b1110, 32'b0000, 32'b0000, 32'b0000, 4);
        chk("t5_pre_ps", 32'(u_def.r_ps), 32'h4);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b1;
        in_seq   = 1'b1;
        #1;
        chk("t5_rst_ps",      32'(u_def.r_ps), 32'h0);
        chk("t5_rst_ov_ps",   32'(u_ov.r_ps),  32'h0);
        chk("t5_rst_det_reg", 32'(def_reg),    32'h0);
        chk("t5_rst_det_out", 32'(def_out),    32'h0);
        chk("t5_rst_ov_out",  32'(ov_out),     32'h0);
        exp_def = 0;
        exp_ov  = 0;
        exp_nov = 0;
        exp_c2  = 0;
        chk_counts();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        in_seq   = 1'b0;
        exp_reg  = 1'b0;
        run(32'b11, 32'b10, 32'b00, 32'b00, 32'b00, 2);
        chk("t5_post_ps", 32'(u_def.r_ps), 32'h0);

        // 6: five back-to-back patterns saturate the 2-bit counter, then clr
        do_clr();
        run(32'h3FFFFFFF, {2'b00, {5{6'b111010}}}, {2'b00, {5{6'b000001}}},
            {2'b00, {5{6'b000001}}}, {2'b00, {5{6'b000001}}}, 30);
        run(32'b11111, 32'b11101, 32'b00000, 32'b00000, 32'b00000, 5);
        chk("t6_pre_ps",    32'(u_def.r_ps), 32'h5);
        chk("t6_pre_ov_ps", 32'(u_ov.r_ps),  32'h3);
        @(negedge clk);
        clr      = 1'b1;
        in_valid = 1'b1;
        in_seq   = 1'b0;
        #1;
        chk("t6_clr_def_out", 32'(def_out), 32'h0);
        chk("t6_clr_ov_out",  32'(ov_out),  32'h0);
        chk("t6_clr_nov_out", 32'(nov_out), 32'h0);
        @(negedge clk);
        clr      = 1'b0;
        in_valid = 1'b0;
        #1;
        exp_def = 0;
        exp_ov  = 0;
        exp_nov = 0;
        exp_c2  = 0;
        chk_counts();
        chk("t6_post_ps",    32'(u_def.r_ps), 32'h0);
        chk("t6_post_ov_ps", 32'(u_ov.r_ps),  32'h0);
        chk("t6_det_reg",    32'(def_reg),    32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
